eth_tx_framer: RTL and testbench
================================

# eth_tx_framer

Byte-wide Ethernet transmit framer. It takes a payload byte stream (destination MAC through end of payload), emits preamble and SFD, and pads short frames. It drives the byte-serial CRC-32 stage (start/update/data) and appends the 4-byte FCS taken from that stage's result. It sits directly upstream of the CRC-32 stage and directly drives the GMII-style transmit byte interface.

## Interface
- `PREAMBLE_LEN`, default 7: number of 0x55 bytes before the SFD.
- `MIN_FRAME`, default 60: minimum bytes before the FCS, with padding included.
- `IFG_CYCLES`, default 12: idle cycles after the FCS.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `s_data` in 8: payload byte.
- `s_valid` in 1: payload byte valid.
- `s_last` in 1: marks the final payload byte.
- `s_ready` out 1: framer accepts `s_data` this cycle.
- `crc_strt` out 1: one-cycle pulse that initialises the CRC register to 0xFFFFFFFF.
- `crc_updatecrc` out 1: CRC stage absorbs `crc_data` at this edge.
- `crc_data` out 8: byte fed to the CRC stage, unreflected.
- `crc_result` in 32: registered CRC value, non-reflected and non-inverted.
- `tx_en` out 1: transmit byte valid.
- `tx_data` out 8: transmit byte.
- `tx_er` out 1: abort marker.
- `busy` out 1: state is not IDLE.
- `underrun` out 1: one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- Counters:
  - `cnt` is 11 bits; it counts PRE bytes, then DATA+PAD bytes, then FCS bytes, then IFG cycles, and clears on every state change.
  - `len` is 11 bits and counts DATA+PAD bytes.
- IDLE → PRE when `s_valid`=1. `s_ready`=0 in IDLE, so the first payload byte is held upstream.
- PRE: emit 0x55 for `PREAMBLE_LEN` cycles, then → SFD.
- SFD: emit 0xD5 for 1 cycle, with `crc_strt`=1 this cycle. Then → DATA.
- DATA:
  - `s_ready`=1.
  - When `s_valid`=1: emit `s_data`, `crc_updatecrc`=1, `crc_data`=`s_data`, `len`++.
  - On `s_last`: if `len`+1 < `MIN_FRAME` → PAD, else → FCS.
- DATA underrun: `s_valid`=0 while in DATA means:
  - emit `tx_er`=1 with `tx_en`=1 and `tx_data`=0x00 for one cycle;
  - pulse `underrun`;
  - no CRC update;
  - → IFG, with no FCS.
- PAD: emit 0x00 with `crc_updatecrc`=1 and `crc_data`=0x00 until `len` = `MIN_FRAME`, then → FCS.
- FCS:
  - `fcs` = ~reflect32(`crc_result`).
  - Emit `fcs[7:0]`, `fcs[15:8]`, `fcs[23:16]`, `fcs[31:24]` on 4 consecutive cycles. `crc_result` is stable during this window because `crc_updatecrc`=0.
  - Then → IFG.
- IFG: `tx_en`=0 for `IFG_CYCLES` cycles, then → IDLE. `s_valid` is ignored in IFG.
- `s_ready`, `crc_strt`, `crc_updatecrc`, `crc_data` are combinational from state and inputs. `crc_data` = 0x00 when not updating.
- Frames longer than 2047 bytes are out of contract: `len` wraps and behaviour is undefined.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, cnt=len=0, `tx_en`=0, `tx_data`=0x00, `tx_er`=0, `busy`=0, `underrun`=0. All combinational outputs evaluate to 0.
- Reset mid-frame: outputs drop immediately. No FCS and no `tx_er` are emitted. The upstream frame is considered lost.
- `tx_en`, `tx_data`, `tx_er`, `underrun` are registered: they lag the state that produces them by 1 cycle.
- The first 0x55 appears on `tx_data` 2 cycles after the edge that samples `s_valid`=1 in IDLE.
- Handshake: a payload byte transfers on an edge where `s_valid`=1 and `s_ready`=1.
- CRC-stage contract: `crc_result` reflects every byte updated at or before edge N by the cycle after edge N.
- `tx_en` is contiguous for `PREAMBLE_LEN`+1+max(N, `MIN_FRAME`)+4 cycles for a good frame of N payload bytes.
- Back-to-back frames: the start-to-start interval is ≥ frame length + `IFG_CYCLES` + 1 cycles.

## Configuration
- `TX_PAD_EN`:
  - Defined: PAD state present; short frames are zero-padded to `MIN_FRAME` and the padding is covered by the FCS.
  - Undefined: PAD state removed; DATA always → FCS on `s_last`, and runt frames go out unpadded.

## Test plan
- 64-byte payload with `s_valid` held high, `crc_result` forced to 0x12345678 during FCS → `tx_data` = 0x55×7, 0xD5, payload, B7, D3, 95, E1. `tx_en` high for 76 cycles, then low for 12 cycles.
- 14-byte payload, `TX_PAD_EN` defined → 46 bytes of 0x00 after the payload, `crc_updatecrc` high for 60 cycles, FCS bytes follow. With the macro undefined → FCS directly after byte 14.
- `s_valid` drops after 20 payload bytes → one `tx_data`=0x00 with `tx_er`=1 and `tx_en`=1, `underrun` pulses once, no FCS, 12 IFG cycles, then IDLE.
- `s_valid` held high continuously across 2 frames → the second preamble starts exactly 13 cycles after the last FCS byte of the first frame. `crc_strt` pulses once per frame, in the SFD cycle.
- `rst` asserted during DATA → `tx_en`=0 and `busy`=0 asynchronously. A new 60-byte frame sent afterwards is correct.
- Reference model: a bench CRC-32 model on the 60 zeros (`TX_PAD_EN`, 0-byte payload is illegal, so use a 1-byte 0x00 payload) → the transmitted FCS matches the model's ~reflect32 output.

Source files
------------

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: byte-wide Ethernet TX framer (preamble/SFD, optional pad, FCS, IFG)
// Ports: clk/rst (async active-low) | s_data/s_valid/s_last/s_ready payload stream
//        crc_strt/crc_updatecrc/crc_data -> CRC-32 stage, crc_result <- CRC-32 stage
//        tx_en/tx_data/tx_er GMII-style byte output | busy, underrun status
// Build option: define TX_PAD_EN to zero-pad runt frames up to MIN_FRAME.
module eth_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        crc_strt,
    output logic        crc_updatecrc,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_result,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        tx_er,
    output logic        busy,
    output logic        underrun
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
`ifdef TX_PAD_EN
    localparam logic [2:0] S_PAD  = 3'd4;
`endif
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_IFG  = 3'd6;

    logic [2:0]  r_state;
    logic [10:0] r_cnt;
    logic [10:0] r_len;
    logic [31:0] w_fcs;
    logic [31:0] w_fcs_sh;
    logic        w_take;
    logic        w_in_pad;

    // FCS is the bit-reversed, inverted CRC register; bytes go out LSB byte first
    for (genvar i = 0; i < 32; i++) begin : g_refl
        assign w_fcs[i] = ~crc_result[31-i];
    end
    assign w_fcs_sh = w_fcs >> {r_cnt[1:0], 3'b000};

`ifdef TX_PAD_EN
    assign w_in_pad = r_state == S_PAD;
`else
    assign w_in_pad = 1'b0;
`endif

    assign s_ready       = r_state == S_DATA;
    assign crc_strt      = r_state == S_SFD;
    assign w_take        = s_ready && s_valid;
    assign crc_updatecrc = w_take || w_in_pad;
    assign crc_data      = w_take ? s_data : 8'h00;
    assign busy          = r_state != S_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
            tx_er    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
            tx_er    <= 1'b0;
            underrun <= 1'b0;
            r_cnt    <= r_cnt + 11'd1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_len <= '0;
                    if (s_valid) r_state <= S_PRE;
                end
                S_PRE: begin
                    tx_en   <= 1'b1;
                    tx_data <= 8'h55;
                    if (r_cnt == 11'(PREAMBLE_LEN - 1)) begin
                        r_state <= S_SFD;
                        r_cnt   <= '0;
                    end
                end
                S_SFD: begin
                    tx_en   <= 1'b1;
                    tx_data <= 8'hD5;
                    r_state <= S_DATA;
                    r_cnt   <= '0;
                end
                S_DATA: begin
                    tx_en <= 1'b1;
                    if (s_valid) begin
                        tx_data <= s_data;
                        r_len   <= r_len + 11'd1;
                        if (s_last) begin
                            r_cnt   <= '0;
`ifdef TX_PAD_EN
                            r_state <= (r_len + 11'd1 < 11'(MIN_FRAME)) ? S_PAD : S_FCS;
`else
                            r_state <= S_FCS;
`endif
                        end
                    end else begin
                        // starved mid-frame: flag the error byte and skip the FCS
                        tx_er    <= 1'b1;
                        underrun <= 1'b1;
                        r_state  <= S_IFG;
                        r_cnt    <= '0;
                    end
                end
`ifdef TX_PAD_EN
                S_PAD: begin
                    tx_en <= 1'b1;
                    r_len <= r_len + 11'd1;
                    if (r_len + 11'd1 == 11'(MIN_FRAME)) begin
                        r_state <= S_FCS;
                        r_cnt   <= '0;
                    end
                end
`endif
                S_FCS: begin
                    tx_en   <= 1'b1;
                    tx_data <= w_fcs_sh[7:0];
                    if (r_cnt[1:0] == 2'd3) begin
                        r_state <= S_IFG;
                        r_cnt   <= '0;
                    end
                end
                S_IFG: begin
                    if (r_cnt == 11'(IFG_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: directed self-checking bench for eth_tx_framer with a CRC-32 stage model
module tb_eth_tx_framer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        crc_strt;
    logic        crc_updatecrc;
    logic [7:0]  crc_data;
    logic [31:0] crc_result;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_er;
    logic        busy;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    eth_tx_framer dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .crc_strt(crc_strt), .crc_updatecrc(crc_updatecrc),
        .crc_data(crc_data), .crc_result(crc_result), .tx_en(tx_en), .tx_data(tx_data),
        .tx_er(tx_er), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // CRC-32 stage: MSB-first register, data bits absorbed LSB first
    logic [31:0] r_crc = 32'hFFFFFFFF;
    bit          force_crc = 1'b0;
    function automatic logic [31:0] stage_step(input logic [31:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
        end
        return c;
    endfunction
    always @(posedge clk) begin
        if (crc_strt) r_crc <= 32'hFFFFFFFF;
        else if (crc_updatecrc) r_crc <= stage_step(r_crc, crc_data);
    end
    assign crc_result = force_crc ? 32'h12345678 : r_crc;

    // independent reference: standard reflected Ethernet CRC-32
    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] r = 32'hFFFFFFFF;
        foreach (q[k]) begin
            r ^= {24'h0, q[k]};
            for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return ~r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // monitor
    logic [7:0] q_d[$];
    logic       q_e[$];
    int hi_runs[$];
    int lo_runs[$];
    int hi_run = 0, lo_run = 0, upd_cnt = 0, strt_cnt = 0, un_cnt = 0, ifg_busy = 0;
    bit prev_en = 0, er_seen = 0;
    always @(negedge clk) begin
        if (tx_en) begin
            q_d.push_back(tx_data);
            q_e.push_back(tx_er);
        end
        if (tx_en && !prev_en) begin
            if (hi_runs.size() > 0) lo_runs.push_back(lo_run);
            lo_run = 0;
        end
        if (!tx_en && prev_en) begin
            hi_runs.push_back(hi_run);
            hi_run = 0;
        end
        if (tx_en) hi_run++;
        else lo_run++;
        prev_en = tx_en;
        upd_cnt  += int'(crc_updatecrc);
        strt_cnt += int'(crc_strt);
        un_cnt   += int'(underrun);
        if (tx_er) er_seen = 1;
        if (er_seen && busy) ifg_busy++;
    end

    task automatic clear();
        q_d.delete(); q_e.delete(); hi_runs.delete(); lo_runs.delete();
        hi_run = 0; lo_run = 0; upd_cnt = 0; strt_cnt = 0; un_cnt = 0; ifg_busy = 0; er_seen = 0;
    endtask

    bit zero_pat = 0;
    function automatic logic [7:0] pay(input int i);
        return zero_pat ? 8'h00 : 8'(i * 7 + 3);
    endfunction

    logic [7:0] exp_q[$];
    task automatic build(input int n);
        logic [7:0]  body[$];
        logic [31:0] f;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) body.push_back(pay(i));
`ifdef TX_PAD_EN
        while (body.size() < 60) body.push_back(8'h00);
`endif
        foreach (body[k]) exp_q.push_back(body[k]);
        f = ref_crc(body);
        exp_q.push_back(f[7:0]); exp_q.push_back(f[15:8]);
        exp_q.push_back(f[23:16]); exp_q.push_back(f[31:24]);
    endtask

    task automatic cmp_frames(input string tag);
        int bad = 0;
        chk({tag, "_len"}, q_d.size(), exp_q.size());
        for (int i = 0; i < q_d.size() && i < exp_q.size(); i++) if (q_d[i] !== exp_q[i]) bad++;
        chk({tag, "_bytes_bad"}, bad, 0);
    endtask

    task automatic send(input int n, input int drop, input bit keep);
        int i = 0, g = 0;
        bit acc;
        s_valid = 1; s_data = pay(0); s_last = (n == 1);
        while (i < n && g < 5000) begin
            @(negedge clk); acc = s_ready;
            @(posedge clk); #1;
            g++;
            if (acc) begin
                i++;
                if (drop > 0 && i == drop) break;
                s_data = pay(i); s_last = (i == n - 1);
            end
        end
        chk("send_timeout", g >= 5000, 0);
        s_valid = keep; s_data = pay(0); s_last = 0;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy && g < 400) begin @(negedge clk); g++; end
        chk({tag, "_idle_to"}, g < 400, 1);
        repeat (3) @(negedge clk);
    endtask

    int er_tot;
    logic [7:0]  zq[$];
    logic [31:0] f6;

    initial begin
        // reset state, with s_valid asserted to show combinational outputs stay low
        s_valid = 1;
        repeat (3) @(negedge clk);
        chk("reset_outs", {tx_en, tx_data, tx_er, busy, underrun, s_ready, crc_strt, crc_updatecrc, crc_data}, 0);
        s_valid = 0;
        @(posedge clk); #2 rst = 1;
        repeat (2) @(posedge clk); #1;

        // T1: 64-byte frame, forced CRC result
        clear(); exp_q.delete(); force_crc = 1;
        build(64);
        exp_q[72] = 8'hB7; exp_q[73] = 8'hD3; exp_q[74] = 8'h95; exp_q[75] = 8'hE1;
        send(64, 0, 0);
        wait_idle("t1");
        repeat (12) @(negedge clk);
        force_crc = 0;
        cmp_frames("t1");
        chk("t1_runs", hi_runs.size(), 1);
        chk("t1_en_len", hi_runs.size() > 0 ? hi_runs[0] : 0, 76);
        chk("t1_ifg_low", lo_run >= 12, 1);
        chk("t1_strt", strt_cnt, 1);
        chk("t1_upd", upd_cnt, 64);
        @(posedge clk); #1;

        // T2: 14-byte runt
        clear(); exp_q.delete();
        build(14);
        send(14, 0, 0);
        wait_idle("t2");
        cmp_frames("t2");
`ifdef TX_PAD_EN
        chk("t2_upd", upd_cnt, 60);
`else
        chk("t2_upd", upd_cnt, 14);
`endif
        @(posedge clk); #1;

        // T3: underrun after 20 bytes
        clear(); exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 20; i++) exp_q.push_back(pay(i));
        exp_q.push_back(8'h00);
        send(40, 20, 0);
        wait_idle("t3");
        cmp_frames("t3");
        er_tot = 0;
        foreach (q_e[k]) er_tot += int'(q_e[k]);
        chk("t3_er_cnt", er_tot, 1);
        chk("t3_er_last", q_e.size() > 0 ? q_e[q_e.size()-1] : 1'b0, 1);
        chk("t3_underrun", un_cnt, 1);
        chk("t3_ifg", ifg_busy, 12);
        @(posedge clk); #1;

        // T4: back-to-back frames with s_valid held high
        clear(); exp_q.delete();
        build(64); build(64);
        send(64, 0, 1);
        send(64, 0, 0);
        wait_idle("t4");
        cmp_frames("t4");
        chk("t4_runs", hi_runs.size(), 2);
        chk("t4_en0", hi_runs.size() > 0 ? hi_runs[0] : 0, 76);
        chk("t4_en1", hi_runs.size() > 1 ? hi_runs[1] : 0, 76);
        chk("t4_gap", lo_runs.size() > 0 ? lo_runs[0] : 0, 13);
        chk("t4_strt", strt_cnt, 2);
        @(posedge clk); #1;

        // T5: asynchronous reset during DATA, then a clean 60-byte frame
        s_valid = 1; s_data = pay(0); s_last = 0;
        repeat (15) @(posedge clk);
        #2;
        chk("t5_in_data", s_ready, 1);
        rst = 0;
        #1;
        chk("t5_rst_outs", {tx_en, tx_er, busy, s_ready, crc_updatecrc}, 0);
        s_valid = 0;
        @(posedge clk); #2 rst = 1;
        repeat (3) @(posedge clk); #1;
        clear(); exp_q.delete();
        build(60);
        send(60, 0, 0);
        wait_idle("t5");
        cmp_frames("t5");
        chk("t5_upd", upd_cnt, 60);
        @(posedge clk); #1;

        // T6: 1-byte zero payload against the reference CRC
        clear(); exp_q.delete(); zero_pat = 1;
        build(1);
        send(1, 0, 0);
        wait_idle("t6");
        cmp_frames("t6");
`ifdef TX_PAD_EN
        repeat (60) zq.push_back(8'h00);
`else
        zq.push_back(8'h00);
`endif
        f6 = ref_crc(zq);
        chk("t6_fcs", q_d.size() >= 4 ? {q_d[q_d.size()-1], q_d[q_d.size()-2], q_d[q_d.size()-3], q_d[q_d.size()-4]} : 32'h0, f6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
